// File: rtl/uart_pkt_decoder.sv
// Frames a UART byte stream (SYNC, LEN, payload, CHK) into a held, checksum-verified packet.
// Latency: pkt_valid and err_pulse rise one clk after the causing byte strobe or timeout.
// Backpressure: none upstream; bytes arriving while a packet is held are dropped as overrun.
module uart_pkt_decoder #(
    parameter int         MAX_LEN   = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 120000,
    localparam int        LW        = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_error,
    output logic          pkt_valid,
    output logic [LW-1:0] pkt_len,
    input  logic [LW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          pkt_ack,
    output logic          err_pulse,
    output logic [2:0]    err_code,
    output logic          busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, HOLD} state_t;

    state_t        state;
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic [7:0]    xsum;
    logic [TW-1:0] tcnt;
    logic [7:0]    mem [2**LW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            pkt_valid <= 1'b0;
            pkt_len   <= '0;
            err_pulse <= 1'b0;
            err_code  <= 3'd0;
            busy      <= 1'b0;
            tcnt      <= '0;
            xsum      <= 8'h00;
            len       <= '0;
            idx       <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid || !busy) tcnt <= '0;
            else                   tcnt <= tcnt + TW'(1);

            case (state)
                HUNT: begin
                    if (in_valid && !in_error && in_data == SYNC_BYTE) begin
                        state <= LEN;
                        busy  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (pkt_ack) begin
                        // The ack frees the buffer, so a same-cycle byte is judged as if in HUNT.
                        pkt_valid <= 1'b0;
                        if (in_valid && !in_error && in_data == SYNC_BYTE) begin
                            state <= LEN;
                            busy  <= 1'b1;
                        end else begin
                            state <= HUNT;
                        end
                    end else if (in_valid) begin
                        err_pulse <= 1'b1;
                        err_code  <= 3'd5;
                    end
                end
                default: begin
                    if (!in_valid) begin
                        if (tcnt == TMAX) begin
                            state     <= HUNT;
                            busy      <= 1'b0;
                            tcnt      <= '0;
                            err_pulse <= 1'b1;
                            err_code  <= 3'd3;
                        end
                    end else if (in_error) begin
                        state     <= HUNT;
                        busy      <= 1'b0;
                        err_pulse <= 1'b1;
                        err_code  <= 3'd4;
                    end else if (state == LEN) begin
                        if (in_data == 8'h00 || in_data > 8'(MAX_LEN)) begin
                            state     <= HUNT;
                            busy      <= 1'b0;
                            err_pulse <= 1'b1;
                            err_code  <= 3'd1;
                        end else begin
                            len   <= in_data[LW-1:0];
                            xsum  <= in_data;
                            idx   <= '0;
                            state <= PAYLOAD;
                        end
                    end else if (state == PAYLOAD) begin
                        xsum <= xsum ^ in_data;
                        idx  <= idx + LW'(1);
                        if (idx == len - LW'(1)) state <= CHECK;
                    end else begin
                        busy <= 1'b0;
                        if (in_data == xsum) begin
                            pkt_valid <= 1'b1;
                            pkt_len   <= len;
                            state     <= HOLD;
                        end else begin
                            state     <= HUNT;
                            err_pulse <= 1'b1;
                            err_code  <= 3'd2;
                        end
                    end
                end
            endcase
        end
    end

    // Only PAYLOAD writes, so a held packet cannot be disturbed by later traffic.
    always_ff @(posedge clk) begin
        if (state == PAYLOAD && in_valid && !in_error)
            mem[idx] <= in_data;
    end

    assign rd_data = (pkt_valid && rd_addr < pkt_len) ? mem[rd_addr] : 8'h00;

endmodule

// File: tb/tb_uart_pkt_decoder.sv
// Directed bench for uart_pkt_decoder with a short timeout for fast idle tests.
module tb_uart_pkt_decoder;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 20;
    localparam int LW      = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_error;
    logic          pkt_valid;
    logic [LW-1:0] pkt_len;
    logic [LW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          pkt_ack;
    logic          err_pulse;
    logic [2:0]    err_code;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_pkt_decoder #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
        .pkt_valid(pkt_valid), .pkt_len(pkt_len), .rd_addr(rd_addr), .rd_data(rd_data),
        .pkt_ack(pkt_ack), .err_pulse(err_pulse), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns at the negedge after the sampling edge.
    task automatic send(input logic [7:0] b, input logic e = 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_error = e;
        @(negedge clk);
        in_valid = 1'b0;
        in_error = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [LW-1:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        #1;
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic ack();
        @(negedge clk);
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_error = 1'b0;
        rd_addr = '0; pkt_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pkt_valid", 32'(pkt_valid), 0);
        chk("rst_pkt_len",   32'(pkt_len),   0);
        chk("rst_err",       32'({err_pulse, err_code}), 0);
        chk("rst_busy",      32'(busy),      0);
        rst_n = 1'b1;

        // Noise ahead of SYNC is dropped silently
        send(8'h00); chk("noise0_err", 32'(err_pulse), 0);
        send(8'hFF); chk("noiseff_err", 32'(err_pulse), 0);
        send(8'h5A); chk("noise5a_busy", 32'(busy), 0);

        // Good packet 03 11 22 33, chk 03
        send(8'hA5); chk("good_busy_len", 32'(busy), 1);
        send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        chk("good_pre_chk_valid", 32'(pkt_valid), 0);
        send(8'h03);
        chk("good_valid", 32'(pkt_valid), 1);
        chk("good_len",   32'(pkt_len),   3);
        chk("good_busy",  32'(busy),      0);
        chk("good_noerr", 32'(err_pulse), 0);
        rd_chk("good_rd0", 5'd0, 8'h11);
        rd_chk("good_rd1", 5'd1, 8'h22);
        rd_chk("good_rd2", 5'd2, 8'h33);
        rd_chk("good_rd3", 5'd3, 8'h00);

        // Overrun while held
        send(8'h55);
        chk("ovr_pulse", 32'(err_pulse), 1);
        chk("ovr_code",  32'(err_code),  5);
        chk("ovr_valid", 32'(pkt_valid), 1);
        rd_chk("ovr_rd1", 5'd1, 8'h22);
        chk("ovr_pulse_gone", 32'(err_pulse), 0);
        ack();
        chk("ack_valid", 32'(pkt_valid), 0);
        rd_chk("ack_rd0", 5'd0, 8'h00);

        // Bad checksum
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h04);
        chk("bchk_pulse", 32'(err_pulse), 1);
        chk("bchk_code",  32'(err_code),  2);
        chk("bchk_valid", 32'(pkt_valid), 0);
        @(negedge clk);
        chk("bchk_once", 32'(err_pulse), 0);
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        chk("p1_valid", 32'(pkt_valid), 1);
        chk("p1_len",   32'(pkt_len),   1);
        rd_chk("p1_rd0", 5'd0, 8'h7E);

        // SYNC in the same cycle as ack goes straight to LEN
        @(negedge clk);
        pkt_ack = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        @(negedge clk);
        pkt_ack = 1'b0; in_valid = 1'b0;
        chk("ackSync_valid", 32'(pkt_valid), 0);
        chk("ackSync_busy",  32'(busy),      1);
        send(8'h01); send(8'hAA); send(8'hAB);
        chk("p2_valid", 32'(pkt_valid), 1);
        rd_chk("p2_rd0", 5'd0, 8'hAA);
        ack();

        // Bad lengths
        send(8'hA5); send(8'h00);
        chk("len0_pulse", 32'(err_pulse), 1);
        chk("len0_code",  32'(err_code),  1);
        chk("len0_busy",  32'(busy),      0);
        send(8'hA5); send(8'h11);
        chk("len17_pulse", 32'(err_pulse), 1);
        chk("len17_code",  32'(err_code),  1);
        send(8'hA5); send(8'h10);
        chk("len16_ok", 32'({err_pulse, busy}), 1);
        send(8'h00, 1'b1);

        // Timeout after TIMEOUT idle cycles
        send(8'hA5); send(8'h02); send(8'h10);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("to_not_yet", 32'({err_pulse, busy}), 1);
        @(negedge clk);
        chk("to_pulse", 32'(err_pulse), 1);
        chk("to_code",  32'(err_code),  3);
        chk("to_busy",  32'(busy),      0);

        // Idle gap of TIMEOUT-2 cycles is tolerated
        send(8'hA5); send(8'h02); send(8'h10);
        repeat (TIMEOUT - 3) @(negedge clk);
        send(8'h20);
        chk("gap_noerr", 32'({err_pulse, busy}), 1);
        send(8'h32);
        chk("gap_valid", 32'(pkt_valid), 1);
        rd_chk("gap_rd1", 5'd1, 8'h20);
        ack();

        // Receiver framing error mid-packet
        send(8'hA5); send(8'h03); send(8'h11, 1'b1);
        chk("frm_pulse", 32'(err_pulse), 1);
        chk("frm_code",  32'(err_code),  4);
        chk("frm_busy",  32'(busy),      0);

        // Reset in PAYLOAD
        send(8'hA5); send(8'h03); send(8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_err",  32'({err_pulse, err_code}), 0);
        chk("mrst_pv",   32'(pkt_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_nopulse", 32'(err_pulse), 0);
        send(8'hA5); send(8'h02); send(8'hAB); send(8'hCD); send(8'h64);
        chk("post_valid", 32'(pkt_valid), 1);
        chk("post_len",   32'(pkt_len),   2);
        rd_chk("post_rd1", 5'd1, 8'hCD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
